// File: rtl/ifetch_pkg.sv
// Shared types and defaults for the instruction-fetch controller.
// Vector defaults, buffer depth and the buffered fetch entry.
package ifetch_pkg;

  localparam logic [31:0] RESET_PC_D  = 32'h0000_0000;
  localparam logic [31:0] IRQ_VEC_D   = 32'h0000_0004;
  localparam logic [31:0] EXC_VEC_D   = 32'h0000_0008;
  localparam int          ROM_WORDS_D = 32;
  localparam int          IFETCH_DEPTH = 2;

  typedef struct packed {
    logic        err;
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_buf.sv
// Two-entry fetch queue; entry 0 is always the head.
// Flush wins over push; push+pop keeps the count.
module ifetch_buf
  import ifetch_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_head,
  output logic [1:0]   o_count,
  output logic         o_full
);

  fetch_entry_t r_e0;
  fetch_entry_t r_e1;
  logic [1:0]   r_cnt;
  logic         w_pop;
  logic         w_push;
  logic         w_full;

  assign w_full = (r_cnt == 2'(IFETCH_DEPTH));
  assign w_pop  = i_pop & (r_cnt != 2'd0);
  assign w_push = i_push & (~w_full | w_pop);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_e0  <= '0;
      r_e1  <= '0;
      r_cnt <= 2'd0;
    end else if (i_flush) begin
      r_cnt <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b11: begin
          if (w_full) begin
            r_e0 <= r_e1;
            r_e1 <= i_data;
          end else begin
            r_e0 <= i_data;
          end
        end
        2'b10: begin
          if (r_cnt == 2'd0) r_e0 <= i_data;
          else               r_e1 <= i_data;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_e0  <= r_e1;
          r_cnt <= r_cnt - 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_head  = r_e0;
  assign o_count = r_cnt;
  assign o_full  = w_full;

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch controller: PC, ROM drive, 2-deep queue, redirect/irq/exc.
// Define IFETCH_IRQ_EN to honour irq; otherwise irq is ignored.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_D,
  parameter logic [31:0] IRQ_VEC   = IRQ_VEC_D,
  parameter logic [31:0] EXC_VEC   = EXC_VEC_D,
  parameter int          ROM_WORDS = ROM_WORDS_D
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] rom_addr,
  output logic        rom_en,
  input  logic [31:0] rom_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        inst_err,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        irq,
  input  logic        exc,
  output logic [31:0] epc,
  output logic        misalign
);

  localparam logic [31:0] ROM_LIMIT = 32'(ROM_WORDS) << 2;

  logic         r_run;
  logic [31:0]  r_fpc;
  logic [31:0]  r_epc;
  logic         r_misalign;
  logic         w_irq;
  logic         w_nonseq;
  logic         w_valid;
  logic         w_pop;
  logic         w_push;
  logic         w_full;
  logic [1:0]   w_cnt;
  fetch_entry_t w_head;
  fetch_entry_t w_new;

`ifdef IFETCH_IRQ_EN
  assign w_irq = irq;
`else
  assign w_irq = irq & 1'b0;
`endif

  assign w_nonseq = exc | w_irq | redirect;
  assign w_valid  = (w_cnt != 2'd0);
  assign w_pop    = w_valid & inst_ready & ~w_nonseq;
  // r_run holds off fetching for the first edge out of reset
  assign w_push   = reset & r_run & ~w_nonseq & (~w_full | w_pop);

  assign w_new.err  = (r_fpc >= ROM_LIMIT);
  assign w_new.pc   = r_fpc;
  assign w_new.inst = rom_data;

  ifetch_buf u_buf (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_nonseq),
    .i_data  (w_new),
    .o_head  (w_head),
    .o_count (w_cnt),
    .o_full  (w_full)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_run      <= 1'b0;
      r_fpc      <= RESET_PC;
      r_epc      <= 32'h0;
      r_misalign <= 1'b0;
    end else begin
      r_run      <= 1'b1;
      r_misalign <= redirect & ~exc & ~w_irq & (|redirect_pc[1:0]);
      if (exc | w_irq) r_epc <= w_valid ? w_head.pc : r_fpc;
      if (exc)           r_fpc <= EXC_VEC;
      else if (w_irq)    r_fpc <= IRQ_VEC;
      else if (redirect) r_fpc <= {redirect_pc[31:2], 2'b00};
      else if (w_push)   r_fpc <= r_fpc + 32'd4;
    end
  end

  assign rom_addr   = r_fpc;
  assign rom_en     = w_push;
  assign inst_valid = w_valid;
  assign inst_out   = w_head.inst;
  assign pc_out     = w_head.pc;
  assign pc_plus4   = w_head.pc + 32'd4;
  assign inst_err   = w_head.err;
  assign epc        = r_epc;
  assign misalign   = r_misalign;

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Random-stimulus bench for ifetch_ctrl against a queue-based model.
// Honours IFETCH_IRQ_EN the same way the design does.
module tb_ifetch_ctrl;
  import ifetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset, inst_ready, redirect, irq, exc;
  logic [31:0] redirect_pc, rom_data;
  logic [31:0] rom_addr, inst_out, pc_out, pc_plus4, epc;
  logic        rom_en, inst_valid, inst_err, misalign;

  always #5 clk = ~clk;

  ifetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .rom_addr    (rom_addr),
    .rom_en      (rom_en),
    .rom_data    (rom_data),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst_out    (inst_out),
    .pc_out      (pc_out),
    .pc_plus4    (pc_plus4),
    .inst_err    (inst_err),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .irq         (irq),
    .exc         (exc),
    .epc         (epc),
    .misalign    (misalign)
  );

  function automatic logic [31:0] romf(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  assign rom_data = romf(rom_addr);

  typedef struct {
    logic        err;
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_fpc, m_epc;
  bit          m_run, m_mis, m_ok;
  int          n_total = 0;
  int          n_bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int rdy_pct, input int ev_pct, input bit rst_lo);
    bit   irqe, ns, pop, fetch;
    ent_t e;
    @(negedge clk);
    if (m_ok) begin
      chk("valid", 32'(inst_valid), 32'(q.size() > 0));
      chk("epc", epc, m_epc);
      chk("misalign", 32'(misalign), 32'(m_mis));
      if (q.size() > 0) begin
        chk("pc_out", pc_out, q[0].pc);
        chk("inst_out", inst_out, q[0].inst);
        chk("pc_plus4", pc_plus4, q[0].pc + 32'd4);
        chk("inst_err", 32'(inst_err), 32'(q[0].err));
      end
    end
    reset       = ~rst_lo;
    inst_ready  = ($urandom_range(99) < rdy_pct);
    redirect    = ($urandom_range(99) < ev_pct);
    exc         = ($urandom_range(199) < ev_pct);
    irq         = ($urandom_range(199) < ev_pct);
    if ($urandom_range(9) == 0)
      redirect_pc = 32'hFFFF_FFF0 + 32'($urandom_range(15));
    else
      redirect_pc = 32'($urandom_range(40)) * 4 +
                    (($urandom_range(3) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
    #1;
`ifdef IFETCH_IRQ_EN
    irqe = irq;
`else
    irqe = 1'b0;
`endif
    ns    = exc || irqe || redirect;
    pop   = (q.size() > 0) && inst_ready && !ns;
    fetch = reset && m_run && !ns && (q.size() < 2 || pop);
    if (m_ok) begin
      chk("rom_en", 32'(rom_en), 32'(fetch));
      chk("rom_addr", rom_addr, m_fpc);
    end
    if (!reset) begin
      q.delete();
      m_fpc = 32'h0;
      m_epc = 32'h0;
      m_run = 0;
      m_mis = 0;
    end else begin
      m_mis = redirect && !exc && !irqe && (redirect_pc % 4 != 0);
      if (exc || irqe) m_epc = (q.size() > 0) ? q[0].pc : m_fpc;
      if (ns) begin
        q.delete();
        if (exc)       m_fpc = 32'h8;
        else if (irqe) m_fpc = 32'h4;
        else           m_fpc = redirect_pc - (redirect_pc % 4);
      end else begin
        if (pop) void'(q.pop_front());
        if (fetch) begin
          e.err  = (m_fpc >= 32'd128);
          e.pc   = m_fpc;
          e.inst = romf(m_fpc);
          q.push_back(e);
          m_fpc = m_fpc + 32'd4;
        end
      end
      m_run = 1;
    end
    m_ok = 1;
    @(posedge clk);
  endtask

  initial begin
    m_ok = 0; m_run = 0; m_mis = 0;
    m_fpc = 0; m_epc = 0;
    reset = 0; inst_ready = 0; redirect = 0;
    irq = 0; exc = 0; redirect_pc = 0;
    repeat (2) step(100, 0, 1);
    #1;
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst", inst_out, 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_pc4", pc_plus4, 32'h4);
    chk("rst_en", 32'(rom_en), 32'h0);
    chk("rst_addr", rom_addr, 32'h0);
    chk("rst_err", 32'(inst_err), 32'h0);
    // straight-line run past the end of the ROM
    repeat (45) step(100, 0, 0);
    repeat (6) step(0, 0, 0);
    repeat (6) step(100, 0, 0);
    repeat (300) step(60, 8, 0);
    repeat (2) step(60, 0, 1);
    repeat (40) step(100, 0, 0);
    repeat (300) step(50, 15, 0);
    repeat (3) step(100, 0, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
